// File: rtl/ibus_wbuf.sv
// Posted-write buffer between the internal-bus master and the BSC; also hosts its entry queue.
// Latency: posted writes complete with zero wait states; pass-through accesses add no cycle.
// Backpressure: M_BUSY stalls the master when the queue is full or ordering requires a drain first.

// Generic circular queue: registered count, head visible combinationally.
module ibus_wbuf_fifo #(
    parameter int W     = 68,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PTR_LAST = CNT_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [CNT_W-1:0] wptr;
    logic [CNT_W-1:0] rptr;

    // Pointers wrap at DEPTH; count tracks occupancy so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= (wptr == PTR_LAST) ? '0 : wptr + CNT_ONE;
            if (pop)  rptr <= (rptr == PTR_LAST) ? '0 : rptr + CNT_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rptr[AW-1:0]];
endmodule

// Posted-write buffer top: address decode, drain FSM and output steering.
module ibus_wbuf #(
    parameter int DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic [31:0] M_A,
    input  logic [31:0] M_DI,
    output logic [31:0] M_DO,
    input  logic [3:0]  M_BA,
    input  logic        M_WE,
    input  logic        M_REQ,
    input  logic        M_LOCK,
    output logic        M_BUSY,
    output logic [31:0] S_A,
    output logic [31:0] S_DO,
    input  logic [31:0] S_DI,
    output logic [3:0]  S_BA,
    output logic        S_WE,
    output logic        S_REQ,
    output logic        S_LOCK,
    input  logic        S_BUSY,
    output logic        FULL,
    output logic        EMPTY
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  ba;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t           state;
    entry_t           in_ent;
    entry_t           head;
    logic [CNT_W-1:0] count;
    logic             ext_area;
    logic             postable;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             unused_ce_f;

    // The falling-phase enable exists only for port uniformity with sibling blocks.
    assign unused_ce_f = CE_F;

    // External areas are 0x0000_0000-0x07FF_FFFF and 0x2000_0000-0x27FF_FFFF (bit 29 ignored).
    assign ext_area = (M_A[31:30] == 2'b00) && (M_A[28:27] == 2'b00);
    assign postable = M_REQ & M_WE & ~M_LOCK & ext_area;

    // Flags are forced to their reset values while RST is high, before the count has cleared.
    assign full  = (count == CNT_FULL) & ~RST;
    assign empty = (count == '0) | RST;
    assign FULL  = full;
    assign EMPTY = empty;

    // A full queue refuses the push even if a pop happens on the same edge.
    assign push = ~RST & CE_R & postable & ~full;
    // The head leaves only once the BSC has finished with it, so it is stable for the transfer.
    assign pop  = (state == ST_WAIT) & CE_R & ~S_BUSY;

    assign in_ent = '{a: M_A, d: M_DI, ba: M_BA};

    ibus_wbuf_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (push),
        .push_dat (in_ent),
        .pop      (pop),
        .head_dat (head),
        .count    (count)
    );

    // Drain FSM: issue the head, wait for the BSC to finish it, then pop and move on.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Leaving on the push edge makes S_REQ rise the very next cycle.
                    if (push || (count != '0)) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (CE_R && !S_BUSY) state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pop) state <= ((count > CNT_ONE) || push) ? ST_ISSUE : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output steering: drain the queue, else pass a non-postable access straight through, else idle.
    always_comb begin
        S_A    = '0;
        S_DO   = '0;
        S_BA   = '0;
        S_WE   = 1'b0;
        S_REQ  = 1'b0;
        S_LOCK = 1'b0;
        M_BUSY = 1'b0;
        if (RST) begin
            M_BUSY = 1'b1;
        end else if ((state != ST_IDLE) || !empty) begin
            if (state != ST_IDLE) begin
                S_A  = head.a;
                S_DO = head.d;
                S_BA = head.ba;
                S_WE = 1'b1;
            end
            S_REQ  = (state == ST_ISSUE);
            // Anything that is not postable must wait for all earlier writes to land.
            M_BUSY = postable ? full : M_REQ;
        end else if (M_REQ && !postable) begin
            S_A    = M_A;
            S_DO   = M_DI;
            S_BA   = M_BA;
            S_WE   = M_WE;
            S_REQ  = M_REQ;
            S_LOCK = M_LOCK;
            M_BUSY = S_BUSY;
        end
    end

    assign M_DO = S_DI;
endmodule
